// File: rtl/rc4_decode.sv
// RC4 PRGA stage: walks the key-scheduled S RAM to produce keystream bytes and
// writes keystream XOR ciphertext into the decrypted RAM, one byte per 11 cycles.
module rc4_decode #(
    parameter int MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] s_memory_address,
    output logic [7:0] s_memory_data,
    output logic       s_memory_write_enable,
    input  logic [7:0] s_memory_q,
    output logic [4:0] encrypted_memory_address,
    input  logic [7:0] encrypted_memory_q,
    output logic [4:0] decrypted_memory_address,
    output logic [7:0] decrypted_memory_data,
    output logic       decrypted_memory_write_enable,
    output logic       finish
);

    localparam int DATA_W = 8;
    localparam logic [4:0] K_LAST = 5'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, INC_I, RD_SI, WT_SI, RD_SJ, WT_SJ,
        WR_SI, WR_SJ, RD_F, WT_F, WR_D, NEXT, DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] i, j;
    logic [4:0]        k;
    logic [DATA_W-1:0] si, sj, f, ct;

    // Control state: the only registers that reset needs to touch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    i <= '0;
                    j <= '0;
                    k <= '0;
                end
                INC_I: i <= i + 8'd1;
                WT_SI: j <= j + s_memory_q;
                NEXT:  if (k != K_LAST) k <= k + 5'd1;
                default: ;
            endcase
        end
    end

    // Datapath captures of synchronous-read memory outputs.
    always_ff @(posedge clk) begin
        case (state)
            WT_SI: si <= s_memory_q;
            WT_SJ: sj <= s_memory_q;
            WT_F: begin
                f  <= s_memory_q;
                ct <= encrypted_memory_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = INC_I;
            INC_I:   state_nxt = RD_SI;
            RD_SI:   state_nxt = WT_SI;
            WT_SI:   state_nxt = RD_SJ;
            RD_SJ:   state_nxt = WT_SJ;
            WT_SJ:   state_nxt = WR_SI;
            WR_SI:   state_nxt = WR_SJ;
            WR_SJ:   state_nxt = RD_F;
            RD_F:    state_nxt = WT_F;
            WT_F:    state_nxt = WR_D;
            WR_D:    state_nxt = NEXT;
            NEXT:    state_nxt = (k == K_LAST) ? DONE : INC_I;
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs; when i==j the WR_SJ write lands last and restores si.
    always_comb begin
        s_memory_address              = '0;
        s_memory_data                 = '0;
        s_memory_write_enable         = 1'b0;
        encrypted_memory_address      = '0;
        decrypted_memory_address      = '0;
        decrypted_memory_data         = '0;
        decrypted_memory_write_enable = 1'b0;
        finish                        = 1'b0;
        case (state)
            RD_SI: s_memory_address = i;
            RD_SJ: s_memory_address = j;
            WR_SI: begin
                s_memory_address      = i;
                s_memory_data         = sj;
                s_memory_write_enable = 1'b1;
            end
            WR_SJ: begin
                s_memory_address      = j;
                s_memory_data         = si;
                s_memory_write_enable = 1'b1;
            end
            RD_F: begin
                s_memory_address         = si + sj;
                encrypted_memory_address = k;
            end
            WR_D: begin
                decrypted_memory_address      = k;
                decrypted_memory_data         = f ^ ct;
                decrypted_memory_write_enable = 1'b1;
            end
            DONE: finish = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_decode.sv
// Directed bench for rc4_decode: constant-memory traces, abort/restart, DONE
// handshake, and a full RC4 run against behavioural S RAM and ciphertext ROM.
module tb_rc4_decode;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] s_addr, s_data, s_q;
    logic       s_we;
    logic [4:0] enc_addr, dec_addr;
    logic [7:0] enc_q, dec_data;
    logic       dec_we, finish;

    always #5 clk = ~clk;

    rc4_decode #(.MSG_LEN(32)) dut (
        .clk                           (clk),
        .reset                         (reset),
        .start                         (start),
        .s_memory_address              (s_addr),
        .s_memory_data                 (s_data),
        .s_memory_write_enable         (s_we),
        .s_memory_q                    (s_q),
        .encrypted_memory_address      (enc_addr),
        .encrypted_memory_q            (enc_q),
        .decrypted_memory_address      (dec_addr),
        .decrypted_memory_data         (dec_data),
        .decrypted_memory_write_enable (dec_we),
        .finish                        (finish)
    );

    // Memory models; const modes override the read data with a fixed byte.
    logic       s_const_mode, enc_const_mode, preload, clr_log;
    logic [7:0] s_const, enc_const;
    logic [7:0] s_mem [256];
    logic [7:0] s_init [256];
    logic [7:0] enc_rom [32];
    logic [7:0] s_q_reg, enc_q_reg;

    always @(posedge clk) begin
        if (preload) s_mem <= s_init;
        else if (s_we) s_mem[s_addr] <= s_data;
        s_q_reg   <= s_mem[s_addr];
        enc_q_reg <= enc_rom[enc_addr];
    end

    assign s_q   = s_const_mode ? s_const : s_q_reg;
    assign enc_q = enc_const_mode ? enc_const : enc_q_reg;

    // Write logger: decrypted RAM, per-address write counts, j and f addresses.
    logic [7:0] dec_mem [32];
    int         wcnt [32];
    logic [7:0] jlog [32];
    logic [7:0] flog [32];
    int         n_dec, n_sj, both_err, cyc;
    logic       prev_we, prev_sj;

    initial cyc = 0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_we <= s_we;
        prev_sj <= s_we && prev_we;
        if (clr_log) begin
            n_dec    <= 0;
            n_sj     <= 0;
            both_err <= 0;
            for (int a = 0; a < 32; a++) wcnt[a] <= 0;
        end else begin
            if (dec_we) begin
                dec_mem[dec_addr] <= dec_data;
                wcnt[dec_addr]    <= wcnt[dec_addr] + 1;
                n_dec             <= n_dec + 1;
            end
            if (s_we && prev_we) begin
                jlog[5'(n_sj)] <= s_addr;
                n_sj           <= n_sj + 1;
            end
            if (prev_sj) flog[5'(n_sj - 1)] <= s_addr;
            if (s_we && dec_we) both_err <= both_err + 1;
        end
    end

    int n_vec = 0;
    int n_miss = 0;
    int t_idle, t_fin;

    task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs_all();
        return 64'({s_addr, s_data, s_we, enc_addr, dec_addr, dec_data, dec_we, finish});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fin(input int limit);
        int c = 0;
        while (!finish && c < limit) begin
            tick();
            c++;
        end
        t_fin = cyc;
        chk_vec("finish_seen", finish, 1);
    endtask

    task automatic wait_dec(input int n);
        int c = 0;
        while (n_dec < n && c < 1000) begin
            tick();
            c++;
        end
        chk_vec("dec_count_reached", n_dec, n);
    endtask

    logic [7:0] jsave [32];
    logic [7:0] fsave [32];
    logic [7:0] ref_s [256];
    logic [7:0] ref_pt [32];

    initial begin
        int bad, bad2, c;
        logic [7:0] key [3];
        logic [7:0] ct9 [9];
        logic [7:0] pt9 [9];
        logic [7:0] ri, rj, tmp;

        reset = 1'b1; start = 1'b1; preload = 1'b0; clr_log = 1'b1;
        s_const_mode = 1'b1; s_const = 8'h01;
        enc_const_mode = 1'b1; enc_const = 8'hAA;
        for (int a = 0; a < 32; a++) enc_rom[a] = 8'h00;
        for (int a = 0; a < 256; a++) s_init[a] = 8'h00;

        // Run A: constant s_q=0x01, enc_q=0xAA.
        tick(); tick();
        chk_vec("reset_outs", outs_all(), 0);
        clr_log = 1'b0; reset = 1'b0;
        t_idle = cyc;
        tick();
        chk_vec("inc_i_outs", outs_all(), 0);
        tick();
        chk_vec("rd_si_addr", {s_we, s_addr}, {1'b0, 8'h01});
        tick(); tick();
        chk_vec("rd_sj_addr", {s_we, s_addr}, {1'b0, 8'h01});
        tick(); tick();
        chk_vec("wr_si", {s_we, s_addr, s_data}, {1'b1, 8'h01, 8'h01});
        tick();
        chk_vec("wr_sj", {s_we, s_addr, s_data}, {1'b1, 8'h01, 8'h01});
        tick();
        chk_vec("rd_f_addr", {s_we, s_addr, enc_addr}, {1'b0, 8'h02, 5'd0});
        tick(); tick();
        chk_vec("wr_d0", {dec_we, s_we, dec_addr, dec_data}, {1'b1, 1'b0, 5'd0, 8'hAB});
        wait_fin(2000);
        chk_vec("latency_a", t_fin - t_idle, 353);
        chk_vec("n_dec_a", n_dec, 32);
        bad = 0;
        for (int a = 0; a < 32; a++) begin
            if (dec_mem[a] !== 8'hAB) bad++;
            if (wcnt[a] != 1) bad++;
            if (jlog[a] !== 8'(a + 1)) bad++;
            if (flog[a] !== 8'h02) bad++;
        end
        chk_vec("const_run_bytes", bad, 0);
        chk_vec("strobe_overlap_a", both_err, 0);

        // Run B: switch s_q to 0xFF after byte 5, abort during byte 10.
        reset = 1'b1; clr_log = 1'b1;
        tick();
        clr_log = 1'b0; reset = 1'b0;
        wait_dec(6);
        s_const = 8'hFF;
        wait_dec(10);
        chk_vec("j_before_switch", jlog[5], 8'h06);
        chk_vec("j_dec_b6", jlog[6], 8'h05);
        chk_vec("j_dec_b9", jlog[9], 8'h02);
        chk_vec("f_addr_ff", flog[7], 8'hFE);
        bad = 0;
        for (int a = 6; a < 10; a++) if (dec_mem[a] !== 8'h55) bad++;
        chk_vec("dec_after_switch", bad, 0);
        chk_vec("dec_before_switch", dec_mem[5], 8'hAB);
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        chk_vec("abort_outs", outs_all(), 0);
        chk_vec("abort_no_byte10", wcnt[10], 0);
        s_const = 8'h01; clr_log = 1'b1;
        tick();
        chk_vec("abort_hold_outs", outs_all(), 0);
        clr_log = 1'b0; reset = 1'b0;
        t_idle = cyc;
        c = 0;
        while (!dec_we && c < 200) begin
            tick();
            c++;
        end
        chk_vec("restart_dec0", {dec_we, dec_addr, dec_data}, {1'b1, 5'd0, 8'hAB});

        // DONE handshake and identical second pass.
        wait_fin(2000);
        chk_vec("latency_restart", t_fin - t_idle, 353);
        tick(); tick(); tick(); tick(); tick();
        chk_vec("done_hold", finish, 1);
        start = 1'b0;
        tick();
        chk_vec("done_drop", finish, 0);
        for (int a = 0; a < 32; a++) begin
            jsave[a] = jlog[a];
            fsave[a] = flog[a];
        end
        clr_log = 1'b1;
        tick();
        clr_log = 1'b0; start = 1'b1;
        t_idle = cyc;
        wait_fin(2000);
        chk_vec("latency_pass2", t_fin - t_idle, 353);
        bad = 0;
        for (int a = 0; a < 32; a++) begin
            if (jlog[a] !== jsave[a] || flog[a] !== fsave[a]) bad++;
            if (wcnt[a] != 1) bad++;
        end
        chk_vec("pass2_same_addrs", bad, 0);

        // Model run: key "Key", first nine bytes are the classic "Plaintext" vector.
        key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
        ct9 = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        pt9 = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
        rj = 8'h00;
        for (int a = 0; a < 256; a++) begin
            rj = rj + s_init[a] + key[a % 3];
            tmp = s_init[a]; s_init[a] = s_init[rj]; s_init[rj] = tmp;
        end
        for (int a = 0; a < 32; a++) enc_rom[a] = (a < 9) ? ct9[a] : 8'(8'h30 + a * 5);
        ref_s = s_init;
        ri = 8'h00; rj = 8'h00;
        for (int n = 0; n < 32; n++) begin
            ri = ri + 8'd1;
            rj = rj + ref_s[ri];
            tmp = ref_s[ri]; ref_s[ri] = ref_s[rj]; ref_s[rj] = tmp;
            ref_pt[n] = enc_rom[n] ^ ref_s[8'(ref_s[ri] + ref_s[rj])];
        end

        start = 1'b0; reset = 1'b1;
        s_const_mode = 1'b0; enc_const_mode = 1'b0;
        preload = 1'b1; clr_log = 1'b1;
        tick();
        preload = 1'b0; clr_log = 1'b0;
        tick();
        reset = 1'b0; start = 1'b1;
        t_idle = cyc;
        wait_fin(2000);
        chk_vec("latency_model", t_fin - t_idle, 353);
        for (int a = 0; a < 9; a++) chk_vec("plaintext_vec", dec_mem[a], pt9[a]);
        bad = 0;
        for (int a = 0; a < 32; a++) if (dec_mem[a] !== ref_pt[a]) bad++;
        chk_vec("model_decrypted", bad, 0);
        bad2 = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== ref_s[a]) bad2++;
        chk_vec("model_final_s", bad2, 0);
        chk_vec("strobe_overlap_m", both_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
